uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// A byte moves on a rising edge where tx_valid && tx_ready; tx_data must be stable while tx_valid is high.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// The byte is latched on the accept edge, so the producer may change tx_data right after.
module uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic        CLK50M,
  input  logic        RST_N,
  uart_tx_if.slave    bus,
  output logic        TX,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  if (DIVISOR < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
    $error("uart_tx: DIVISOR must be >= 2 and STOP_BITS must be 1 or 2");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             parity_bit;
  logic             stop_idx;
  logic             tx_q;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge CLK50M or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      parity_bit <= 1'b0;
      stop_idx   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          if (bus.tx_valid) begin
            shift      <= bus.tx_data;
            parity_bit <= (^bus.tx_data) ^ (PARITY_ODD != 0);
            bit_idx    <= 3'd0;
            stop_idx   <= 1'b0;
            state      <= START;
            tx_q       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx_q     <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_q  <= parity_bit;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              // shift[0] is the bit on the line now; shift[1] is the next one
              tx_q <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (STOP_BITS == 2 && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign TX           = tx_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with DIVISOR=16: 8N1, 8E1, 8O1 and 8N2 instances share clock and reset.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data    [4];
  logic       valid   [4];
  logic       ready   [4];
  logic       tx_line [4];
  logic       busy    [4];
  logic [2:0] fsm     [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_if bus ();
    assign bus.tx_data  = data[g];
    assign bus.tx_valid = valid[g];
    assign ready[g]     = bus.tx_ready;

    uart_tx #(
      .CLK_FREQ   (16),
      .BAUD       (1),
      .PARITY_EN  ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD ((g == 2) ? 1 : 0),
      .STOP_BITS  ((g == 3) ? 2 : 1)
    ) u_dut (
      .CLK50M    (clk),
      .RST_N     (rst_n),
      .bus       (bus),
      .TX        (tx_line[g]),
      .busy      (busy[g]),
      .fsm_state (fsm[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check($sformatf("%s tx[%0d]", tag, k), 32'(tx_line[k]), 32'd1);
    check($sformatf("%s ready[%0d]", tag, k), 32'(ready[k]), 32'd1);
    check($sformatf("%s busy[%0d]", tag, k), 32'(busy[k]), 32'd0);
  endtask

  // Entered on a negedge with the DUT idle; the accept happens on the next posedge.
  // frame holds the line bits in send order (bit 0 = start bit), data byte is frame[8:1].
  // mode 0: drop valid after accept; 1: keep valid high and present next_data; 2: scramble inputs while busy.
  task automatic send_frame(input int k, input logic [11:0] frame, input int nbits,
                            input int mode, input logic [7:0] next_data, input string tag);
    data[k]  = frame[8:1];
    valid[k] = 1'b1;
    check({tag, " tx_pre"}, 32'(tx_line[k]), 32'd1);
    check({tag, " ready_pre"}, 32'(ready[k]), 32'd1);
    for (int off = 0; off <= 16 * nbits; off++) begin
      @(negedge clk);
      if (off == 0) begin
        check({tag, " start_tx"}, 32'(tx_line[k]), 32'd0);
        check({tag, " start_state"}, 32'(fsm[k]), 32'd1);
        if (mode == 1) data[k] = next_data;
        else if (mode == 0) valid[k] = 1'b0;
      end
      if (mode == 2) begin
        if (off < 16 * nbits - 1) begin
          data[k]  = 8'($urandom);
          valid[k] = 1'($urandom_range(0, 1));
        end else begin
          valid[k] = 1'b0;
        end
      end
      if (off % 16 == 8)
        check($sformatf("%s bit%0d", tag, off / 16), 32'(tx_line[k]), 32'(frame[off / 16]));
      if (off < 16 * nbits) begin
        check($sformatf("%s ready@%0d", tag, off), 32'(ready[k]), 32'd0);
      end else begin
        check({tag, " ready_end"}, 32'(ready[k]), 32'd1);
        check({tag, " busy_end"}, 32'(busy[k]), 32'd0);
        check({tag, " tx_end"}, 32'(tx_line[k]), 32'd1);
        check({tag, " state_end"}, 32'(fsm[k]), 32'd0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data[k]  = 8'h00;
      valid[k] = 1'b0;
    end

    // Reset held 3 cycles, then 50 idle cycles
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) check_idle(k, "in_reset");
    end
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) check_idle(k, "idle");
    end

    // 0x61, 8N1: 0,1,0,0,0,0,1,1,0,1 over 160 cycles
    send_frame(0, {2'b11, 1'b1, 8'h61, 1'b0}, 10, 0, 8'h00, "n81_61");

    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    send_frame(1, {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0, 8'h00, "e81_07");
    send_frame(2, {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0, 8'h00, "o81_07");

    // Back-to-back with two stop bits: the second accept follows one idle cycle
    send_frame(3, {1'b1, 2'b11, 8'hA5, 1'b0}, 11, 1, 8'h3C, "n82_a5");
    send_frame(3, {1'b1, 2'b11, 8'h3C, 1'b0}, 11, 0, 8'h00, "n82_3c");
    repeat (20) begin
      @(negedge clk);
      check_idle(3, "after_b2b");
    end

    // Abort 0xFF during D3 (line bit 4, offsets 64..79)
    data[0]  = 8'hFF;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (72) @(negedge clk);
    check("abort pre_state", 32'(fsm[0]), 32'd2);
    check("abort pre_busy", 32'(busy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle(0, "abort_now");
    check("abort state", 32'(fsm[0]), 32'd0);
    repeat (2) @(negedge clk);
    check_idle(0, "abort_held");
    rst_n = 1'b1;
    send_frame(0, {2'b11, 1'b1, 8'h00, 1'b0}, 10, 0, 8'h00, "post_abort_00");
    repeat (5) begin
      @(negedge clk);
      check_idle(0, "post_abort_idle");
    end

    // Inputs scrambled while busy; only 0x5A goes out, and only once
    send_frame(0, {2'b11, 1'b1, 8'h5A, 1'b0}, 10, 2, 8'h00, "scramble_5a");
    repeat (20) begin
      @(negedge clk);
      check_idle(0, "after_scramble");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
